dcsg_mixer: RTL

//  Consumer of the two signed 14-bit DCSG outputs (sound_out0/sound_out1 of the dual DCSG block).

---
 rtl/dcsg_mixer.sv | 112 +++++++++++
 1 files changed

// File: rtl/dcsg_mixer.sv
// Dual-DCSG audio mixer: per-chip 4-bit Q2.2 gain, sum, box-filter decimation over
// 2**DECIM_LOG2 enable ticks, saturated signed 16-bit output with a 1-clock strobe.
module dcsg_mixer #(
  parameter logic [7:0] IO_ADDRESS = 8'h7C,
  parameter int         DECIM_LOG2 = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic signed [13:0] sound_in0,
  input  logic signed [13:0] sound_in1,
  input  logic               bus_ioreq,
  input  logic [7:0]         bus_address,
  input  logic               bus_write,
  input  logic               bus_valid,
  output logic               bus_ready,
  input  logic [7:0]         bus_wdata,
  output logic signed [15:0] sound_out,
  output logic               sound_valid
);

  localparam int AW = 20 + DECIM_LOG2;
  localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

  // Bus handshake: a request is accepted in the same clock it is presented
  // (bus_ready = hit & bus_valid); no wait states, reads carry no data.
  logic       hit;
  logic [3:0] gain0;
  logic [3:0] gain1;

  assign hit       = bus_ioreq && ({bus_address[7], 1'b1, bus_address[5:0]} == IO_ADDRESS);
  assign bus_ready = hit && bus_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gain0 <= 4'd4;
      gain1 <= 4'd4;
    end else if (bus_ready && bus_write) begin
      gain1 <= bus_wdata[7:4];
      gain0 <= bus_wdata[3:0];
    end
  end

  // Stage 1: gain multiply; uses the gain registers before any same-clock write.
  logic signed [18:0] in0_x;
  logic signed [18:0] in1_x;
  logic signed [18:0] g0_x;
  logic signed [18:0] g1_x;
  logic signed [18:0] p0;
  logic signed [18:0] p1;
  logic               v1;

  assign in0_x = 19'(sound_in0);
  assign in1_x = 19'(sound_in1);
  assign g0_x  = {15'd0, gain0};
  assign g1_x  = {15'd0, gain1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0 <= '0;
      p1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= enable;
      if (enable) begin
        p0 <= in0_x * g0_x;
        p1 <= in1_x * g1_x;
      end
    end
  end

  // Stage 2: accumulate the window, then scale by 1/(4 * 2**DECIM_LOG2) and clamp.
  logic signed [19:0]     s;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   acc_next;
  logic signed [AW-1:0]   t;
  logic signed [15:0]     sat;
  logic [DECIM_LOG2-1:0]  cnt;

  always_comb begin
    s        = 20'(p0) + 20'(p1);
    acc_next = acc + AW'(s);
    t        = acc_next >>> (DECIM_LOG2 + 2);
    if (t > SAT_MAX)      sat = 16'sh7FFF;
    else if (t < SAT_MIN) sat = 16'sh8000;
    else                  sat = t[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc         <= '0;
      cnt         <= '0;
      sound_out   <= '0;
      sound_valid <= 1'b0;
    end else begin
      sound_valid <= 1'b0;
      if (v1) begin
        if (cnt == '1) begin
          sound_out   <= sat;
          sound_valid <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
        end else begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
